// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_write_arbiter
//  Purpose  : Arbitrates ALU and load writebacks onto a single register-file
//             write port and counts cycles in which both requesters collide.
//             Define RF_WRITE_ARB_RR_EN for round-robin tie-breaking;
//             otherwise the load requester always wins a tie.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_write_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_reg,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_reg,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              WriteReg,
    output logic [ADDR_W-1:0] DstReg,
    output logic [DATA_W-1:0] DstData,
    output logic [CNT_W-1:0]  conflict_cnt
);

    localparam logic [CNT_W-1:0]  c_cntMax  = {CNT_W{1'b1}};
    localparam logic [ADDR_W-1:0] c_zeroReg = '0;

    logic              r_lastGnt;
    logic              r_writeReg;
    logic [ADDR_W-1:0] r_dstReg;
    logic [DATA_W-1:0] r_dstData;
    logic [CNT_W-1:0]  r_conflictCnt;

    logic              w_bothValid;
    logic              w_tieWinner;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_xfer;
    logic [ADDR_W-1:0] w_winReg;
    logic [DATA_W-1:0] w_winData;

    assign w_bothValid = req0_valid & req1_valid;

`ifdef RF_WRITE_ARB_RR_EN
    // On a tie the requester that did not win last time goes next.
    assign w_tieWinner = ~r_lastGnt;
`else
    assign w_tieWinner = 1'b1;
`endif

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        // Readies are forced low while reset is held, independent of state.
        if (rst && !stall) begin
            if (w_bothValid) begin
                w_gnt1 = w_tieWinner;
                w_gnt0 = ~w_tieWinner;
            end else begin
                w_gnt0 = req0_valid;
                w_gnt1 = req1_valid;
            end
        end
    end

    assign w_xfer    = w_gnt0 | w_gnt1;
    assign w_winReg  = w_gnt1 ? req1_reg  : req0_reg;
    assign w_winData = w_gnt1 ? req1_data : req0_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lastGnt     <= 1'b1;
            r_writeReg    <= 1'b0;
            r_dstReg      <= '0;
            r_dstData     <= '0;
            r_conflictCnt <= '0;
        end else begin
            r_lastGnt  <= w_xfer ? w_gnt1 : r_lastGnt;
            // A register-0 transfer is accepted but never reaches the file.
            r_writeReg <= w_xfer && (w_winReg != c_zeroReg);
            if (w_xfer) begin
                r_dstReg  <= w_winReg;
                r_dstData <= w_winData;
            end
            if (w_bothValid && (r_conflictCnt != c_cntMax)) begin
                r_conflictCnt <= r_conflictCnt + 1'b1;
            end
        end
    end

    assign req0_ready   = w_gnt0;
    assign req1_ready   = w_gnt1;
    assign WriteReg     = r_writeReg;
    assign DstReg       = r_dstReg;
    assign DstData      = r_dstData;
    assign conflict_cnt = r_conflictCnt;

endmodule
`default_nettype wire
